// File: rtl/mat_switch_if.sv
// rtl/mat_switch_if.sv - send/receive port bundle between the MatCores and mat_switch
// Vector elements are IEEE-754 single-precision bit patterns.
interface mat_switch_if #(
    parameter int SWITCH_WIDTH          = 16,
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
);
    logic                             switch_send_ready    [SWITCH_CORE_SIZE];
    logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx [SWITCH_CORE_SIZE];
    logic [31:0]                      switch_send_data     [SWITCH_CORE_SIZE][SWITCH_WIDTH];
    logic                             switch_send_ok       [SWITCH_CORE_SIZE];

    logic                             switch_recv_request  [SWITCH_CORE_SIZE];
    logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_recv_core_idx [SWITCH_CORE_SIZE];
    logic                             switch_recv_ready    [SWITCH_CORE_SIZE];
    logic [31:0]                      switch_recv_data     [SWITCH_CORE_SIZE][SWITCH_WIDTH];

    // Core side
    modport master (
        output switch_send_ready, switch_send_core_idx, switch_send_data,
        output switch_recv_request, switch_recv_core_idx,
        input  switch_send_ok, switch_recv_ready, switch_recv_data
    );

    // Switch side
    modport slave (
        input  switch_send_ready, switch_send_core_idx, switch_send_data,
        input  switch_recv_request, switch_recv_core_idx,
        output switch_send_ok, switch_recv_ready, switch_recv_data
    );
endinterface

// File: rtl/mat_switch.sv
// rtl/mat_switch.sv - inter-core switch with a one-entry mailbox per (source, destination) pair
// Senders fill row s, receivers drain column d; all cores are served in parallel each cycle.
module mat_switch #(
    parameter int SWITCH_WIDTH     = 16,
    parameter int SWITCH_CORE_SIZE = 4
) (
    input  logic          clock,
    input  logic          reset,
    mat_switch_if.slave   sw
);
    localparam int N = SWITCH_CORE_SIZE;
    localparam int W = SWITCH_WIDTH;
    localparam int A = $clog2(SWITCH_CORE_SIZE);

    logic [N-1:0] full [N];          // full[s][d]
    logic [31:0]  mbox [N][N][W];
    logic [N-1:0] send_ok_q;
    logic [N-1:0] recv_ready_q;
    logic [31:0]  recv_data_q [N][W];

    logic [N-1:0] capture;
    logic [N-1:0] deliver;

    // Both decisions use pre-edge state, so a drained mailbox cannot refill on the same edge.
    always_comb begin
        capture = '0;
        deliver = '0;
        for (int s = 0; s < N; s++) begin
            capture[s] = sw.switch_send_ready[s] && !send_ok_q[s]
                         && !full[s][sw.switch_send_core_idx[s]];
        end
        for (int d = 0; d < N; d++) begin
            deliver[d] = sw.switch_recv_request[d] && !recv_ready_q[d]
                         && full[sw.switch_recv_core_idx[d]][d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < N; s++) begin
                full[s] <= '0;
            end
            send_ok_q    <= '0;
            recv_ready_q <= '0;
        end else begin
            for (int s = 0; s < N; s++) begin
                for (int d = 0; d < N; d++) begin
                    if (capture[s] && sw.switch_send_core_idx[s] == A'(d)) begin
                        full[s][d] <= 1'b1;
                    end else if (deliver[d] && sw.switch_recv_core_idx[d] == A'(s)) begin
                        full[s][d] <= 1'b0;
                    end
                end
            end
            send_ok_q    <= capture;
            recv_ready_q <= deliver;
        end
    end

    // Mailbox payload is qualified by full, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int s = 0; s < N; s++) begin
            if (capture[s]) begin
                for (int i = 0; i < W; i++) begin
                    mbox[s][sw.switch_send_core_idx[s]][i] <= sw.switch_send_data[s][i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int d = 0; d < N; d++) begin
                for (int i = 0; i < W; i++) begin
                    recv_data_q[d][i] <= '0;
                end
            end
        end else begin
            for (int d = 0; d < N; d++) begin
                if (deliver[d]) begin
                    for (int i = 0; i < W; i++) begin
                        recv_data_q[d][i] <= mbox[sw.switch_recv_core_idx[d]][d][i];
                    end
                end
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_out
        assign sw.switch_send_ok[c]    = send_ok_q[c];
        assign sw.switch_recv_ready[c] = recv_ready_q[c];
        for (genvar i = 0; i < W; i++) begin : g_data
            assign sw.switch_recv_data[c][i] = recv_data_q[c][i];
        end
    end
endmodule

// File: tb/tb_mat_switch.sv
// tb/tb_mat_switch.sv - directed self-checking bench for mat_switch
module tb_mat_switch;
    localparam int N = 4;
    localparam int W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mat_switch_if #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N)) sw ();

    mat_switch #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N)) dut (
        .clock (clock),
        .reset (reset),
        .sw    (sw)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // IEEE-754 single-precision encoding of a small positive integer
    function automatic logic [31:0] f2b(input int n);
        int e;
        e = 0;
        for (int k = 0; k < 24; k++) begin
            if ((n >> k) != 0) e = k;
        end
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_send(input int c, input int dst, input int base);
        sw.switch_send_ready[c]    = 1'b1;
        sw.switch_send_core_idx[c] = 2'(dst);
        for (int i = 0; i < W; i++) sw.switch_send_data[c][i] = f2b(base + i);
    endtask

    task automatic start_recv(input int c, input int src);
        sw.switch_recv_request[c]  = 1'b1;
        sw.switch_recv_core_idx[c] = 2'(src);
    endtask

    task automatic check_vec(input string tag, input int d, input int base);
        for (int i = 0; i < W; i++) begin
            check($sformatf("%s[%0d]", tag, i), sw.switch_recv_data[d][i], f2b(base + i));
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] ok_exp, input logic [3:0] rdy_exp);
        for (int c = 0; c < N; c++) begin
            check($sformatf("%s_send_ok%0d", tag, c), 32'(sw.switch_send_ok[c]), 32'(ok_exp[c]));
            check($sformatf("%s_recv_ready%0d", tag, c), 32'(sw.switch_recv_ready[c]), 32'(rdy_exp[c]));
        end
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            sw.switch_send_ready[c]    = 1'b0;
            sw.switch_send_core_idx[c] = '0;
            sw.switch_recv_request[c]  = 1'b0;
            sw.switch_recv_core_idx[c] = '0;
            for (int i = 0; i < W; i++) sw.switch_send_data[c][i] = '0;
        end

        // Reset with every request line high: nothing may be captured or delivered.
        for (int c = 0; c < N; c++) begin
            start_send(c, c, 200);
            start_recv(c, c);
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_flags("reset", 4'b0000, 4'b0000);
            for (int c = 0; c < N; c++) check($sformatf("reset_data%0d", c), sw.switch_recv_data[c][0], 32'h0);
        end
        for (int c = 0; c < N; c++) begin
            sw.switch_send_ready[c]   = 1'b0;
            sw.switch_recv_request[c] = 1'b0;
        end
        reset = 1'b0;
        tick();

        // Basic transfer 0 -> 2 of {1.0..16.0}
        start_send(0, 2, 1);
        tick();
        check_flags("basic_capture", 4'b0001, 4'b0000);
        sw.switch_send_ready[0] = 1'b0;
        tick();
        check_flags("basic_idle", 4'b0000, 4'b0000);
        start_recv(2, 0);
        tick();
        check_flags("basic_deliver", 4'b0000, 4'b0100);
        check("basic_lit_first", sw.switch_recv_data[2][0], 32'h3F80_0000);
        check("basic_lit_last", sw.switch_recv_data[2][15], 32'h4180_0000);
        check_vec("basic_data", 2, 1);
        sw.switch_recv_request[2] = 1'b0;
        tick();
        check_flags("basic_after", 4'b0000, 4'b0000);
        check("basic_hold", sw.switch_recv_data[2][7], f2b(8));
        // Mailbox 0->2 must now be empty.
        start_recv(2, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("basic_empty_after", 32'(sw.switch_recv_ready[2]), 32'h0);
        end
        sw.switch_recv_request[2] = 1'b0;
        tick();

        // Blocking on full: core 1 sends A then B to core 3.
        start_send(1, 3, 17);
        tick();
        check("block_A_ok", 32'(sw.switch_send_ok[1]), 32'h1);
        start_send(1, 3, 33);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("block_B_stall", 32'(sw.switch_send_ok[1]), 32'h0);
        end
        start_recv(3, 1);
        tick();
        check_flags("block_drain_A", 4'b0000, 4'b1000);
        check_vec("block_A_data", 3, 17);
        sw.switch_recv_request[3] = 1'b0;
        tick();
        check_flags("block_B_capture", 4'b0010, 4'b0000);
        sw.switch_send_ready[1] = 1'b0;
        start_recv(3, 1);
        tick();
        check_flags("block_drain_B", 4'b0000, 4'b1000);
        check_vec("block_B_data", 3, 33);
        sw.switch_recv_request[3] = 1'b0;
        tick();

        // Receive before send: core 3 waits on core 0.
        start_recv(3, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("early_wait", 32'(sw.switch_recv_ready[3]), 32'h0);
        end
        start_send(0, 3, 49);
        tick();
        check_flags("early_capture", 4'b0001, 4'b0000);
        sw.switch_send_ready[0] = 1'b0;
        tick();
        check_flags("early_deliver", 4'b0000, 4'b1000);
        check_vec("early_data", 3, 49);
        sw.switch_recv_request[3] = 1'b0;
        tick();

        // Parallel and loopback: 0->1, 1->0, 2->2, 3->1 with all receives pending.
        start_recv(0, 1);
        start_recv(1, 0);
        start_recv(2, 2);
        start_recv(3, 0);
        start_send(0, 1, 65);
        start_send(1, 0, 81);
        start_send(2, 2, 97);
        start_send(3, 1, 113);
        tick();
        check_flags("par_capture", 4'b1111, 4'b0000);
        for (int c = 0; c < N; c++) sw.switch_send_ready[c] = 1'b0;
        tick();
        check_flags("par_deliver", 4'b0000, 4'b0111);
        check_vec("par_data0", 0, 81);
        check_vec("par_data1", 1, 65);
        check_vec("par_data2", 2, 97);
        for (int c = 0; c < N; c++) sw.switch_recv_request[c] = 1'b0;
        tick();
        check_flags("par_idle", 4'b0000, 4'b0000);
        start_recv(1, 3);
        tick();
        check_flags("par_late", 4'b0000, 4'b0010);
        check_vec("par_data31", 1, 113);
        sw.switch_recv_request[1] = 1'b0;
        tick();

        // Reset mid-flight discards the buffered 0->2 vector.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start_send(0, 2, 129);
        tick();
        check("mid_capture", 32'(sw.switch_send_ok[0]), 32'h1);
        sw.switch_send_ready[0] = 1'b0;
        reset = 1'b1;
        tick();
        check_flags("mid_reset", 4'b0000, 4'b0000);
        check("mid_reset_data", sw.switch_recv_data[2][0], 32'h0);
        reset = 1'b0;
        start_recv(2, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_stall", 32'(sw.switch_recv_ready[2]), 32'h0);
            check("mid_data", sw.switch_recv_data[2][0], 32'h0);
        end
        sw.switch_recv_request[2] = 1'b0;

        // A capture pending at a reset edge must not pulse send_ok.
        start_send(1, 0, 150);
        reset = 1'b1;
        tick();
        check("rst_suppress_ok", 32'(sw.switch_send_ok[1]), 32'h0);
        sw.switch_send_ready[1] = 1'b0;
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mat_switch.md
# mat_switch

Inter-core switch serving the `switch_send_*` / `switch_recv_*` ports of every MatCore. It holds a one-entry mailbox per (source, destination) core pair. A core's send is accepted into its mailbox independently of the receiver. A receive request naming a source drains that pair's mailbox back to the requesting core. This decouples senders from receivers, so two cores can exchange vectors without both being ready in the same cycle.

## Interface
- `SWITCH_WIDTH`, 16, shortreal elements per transfer.
- `SWITCH_CORE_SIZE`, 4, number of attached cores; must be a power of 2 and ≥2.
- `SWITCH_CORE_ADDR_SIZE`, `$clog2(SWITCH_CORE_SIZE)`, core index width (derived).

Ports (arrays indexed by attached core `c`):
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `switch_send_ready[c]`  in  1  core c requests a send.
- `switch_send_core_idx[c]`  in  SWITCH_CORE_ADDR_SIZE  destination core of c's send.
- `switch_send_data[c][SWITCH_WIDTH]`  in  shortreal  vector to send.
- `switch_send_ok[c]`  out  1  one-cycle pulse: c's send was captured.
- `switch_recv_request[c]`  in  1  core c requests a receive.
- `switch_recv_core_idx[c]`  in  SWITCH_CORE_ADDR_SIZE  source core c wants to receive from.
- `switch_recv_ready[c]`  out  1  one-cycle pulse: `switch_recv_data[c]` is valid.
- `switch_recv_data[c][SWITCH_WIDTH]`  out  shortreal  delivered vector; holds its value until the next delivery.

## Operation
- State per pair (s,d): `full[s][d]`, `mbox[s][d][SWITCH_WIDTH]`. There are N² mailboxes.
- **Capture, core s, evaluated at each rising edge.**
  - Condition: `send_ready[s]` && !`send_ok[s]` && !`full[s][idx]`, where idx = `send_core_idx[s]`.
  - Action: `mbox[s][idx]` ← `send_data[s]`, `full[s][idx]` ← 1, and `send_ok[s]` is 1 for the next cycle.
  - The !`send_ok` term blocks a second capture while the core is still deasserting after seeing ok.
- **Delivery, core d, evaluated at each rising edge.**
  - Condition: `recv_request[d]` && !`recv_ready[d]` && `full[src][d]`, where src = `recv_core_idx[d]`.
  - Action: `recv_data[d]` ← `mbox[src][d]`, `full[src][d]` ← 0, and `recv_ready[d]` is 1 for the next cycle.
- `send_ok` and `recv_ready` are registered. Each is high for exactly one cycle per transfer and never high in two consecutive cycles.
- **Blocking.**
  - Send to a full mailbox: the sender keeps waiting and `send_ok` stays 0.
  - Receive from an empty mailbox: the receiver keeps waiting and `recv_ready` stays 0.
  - Neither condition is an error.
- **Loopback.** s == d is legal and uses `mbox[s][s]`.
- **Same-edge capture and drain on one pair.** Capture is evaluated on the pre-edge `full` value. A full mailbox drained at edge t therefore cannot be refilled at edge t; the earliest refill is edge t+1.
- **No contention between pairs.**
  - Each core has at most one send and one receive outstanding.
  - Only sender s writes row s; only receiver d drains column d.
  - All cores are evaluated in parallel every cycle with no arbitration.
- **Ordering.** Transfers on one pair are strictly FIFO with depth 1. No ordering is guaranteed across different pairs.
- **Request-line rules.**
  - Inputs are sampled only while the corresponding request line is high.
  - `send_data`, `send_core_idx` and `recv_core_idx` must be held stable while their request is high.

## Timing
- **Reset** (synchronous, at an edge with `reset`=1). All `full` ← 0, all `send_ok` ← 0, all `recv_ready` ← 0, all `recv_data` ← 0.0. Mailbox data is don't-care.
- **Reset mid-operation.** Buffered vectors are discarded. Any `send_ok` or `recv_ready` pulse due in the following cycle is suppressed.
- **Send latency.** `send_ready` high before edge t with the mailbox empty gives `send_ok` high during cycle t+1.
- **Send-to-receive latency, minimum 2 edges.** If the capture occurs at edge t and the request is already pending, delivery occurs at edge t+1 and `recv_ready` is high during cycle t+2.
- **Receive of a pre-filled mailbox.** Delivery occurs at the first edge with the request high; `recv_ready` is high the following cycle.
- **Throughput per pair.** One transfer every 2 cycles when the sender and receiver each turn around immediately.

## Test plan
- **Reset.** Drive reset for 2 cycles with all requests high → all `send_ok`=0, all `recv_ready`=0, all `recv_data`=0.0.
- **Basic transfer.**
  - Stimulus: core 0 sends {1.0..16.0} to core 2; core 2 requests from 0 two cycles later.
  - Response: `send_ok[0]` pulses 1 cycle after send; `recv_ready[2]` pulses with data {1.0..16.0}; `full[0][2]` is 0 afterwards.
- **Blocking on full.** Core 1 sends A then B to core 3 with no receive → A gets `send_ok`, B stalls. Core 3 then receives → A is delivered, B is captured next edge, and a second receive delivers B.
- **Receive before send.** Core 3 requests from core 0 for 5 cycles, then core 0 sends V → `recv_ready[3]`=0 throughout the wait; `recv_ready[3]` pulses with V 2 cycles after the send edge.
- **Parallel and loopback.**
  - Stimulus: in the same cycle, 0→1, 1→0, 2→2 and 3→1, with all four receives pending.
  - Response: all three mailboxes addressed by pending receives (0→1, 1→0, 2→2) deliver in the same cycle. The 3→1 vector waits in `mbox[3][1]` until core 1 requests from 3.
- **Reset mid-flight.** Capture 0→2, assert reset before the receive → the subsequent receive from 0 stalls (mailbox empty) and `recv_data[2]` stays 0.0.
